// File: rtl/sram_arbiter_if.sv
// Request/response bundle for sram_arbiter: the read and write client ports,
// the sram_iface transaction signals, and the watchdog error pulse.
// slave = arbiter view, master = surrounding logic (clients + sram_iface).
interface sram_arbiter_if #(
    parameter int unsigned ADDR_BITS = 16,
    parameter int unsigned DATA_BITS = 24
);
    logic                 rd_req;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [DATA_BITS-1:0] rd_data;
    logic                 rd_valid;

    logic                 wr_req;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [DATA_BITS-1:0] wr_data;
    logic                 wr_done;

    logic                 io_start;
    logic                 io_writemode;
    logic [ADDR_BITS-1:0] io_address;
    logic [DATA_BITS-1:0] io_w_data;
    logic [DATA_BITS-1:0] io_r_data;
    logic                 io_done;

    logic                 err_timeout;

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, io_r_data, io_done,
        output rd_data, rd_valid, wr_done, io_start, io_writemode, io_address,
               io_w_data, err_timeout
    );

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, io_r_data, io_done,
        input  rd_data, rd_valid, wr_done, io_start, io_writemode, io_address,
               io_w_data, err_timeout
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of sram_iface.
// Each granted request becomes one sram_iface transaction
// (IDLE -> ISSUE -> WAIT -> DONE) closed by a one-cycle rd_valid/wr_done pulse.
// Optional WAIT watchdog enabled by defining SRAM_ARB_TIMEOUT_EN.
module sram_arbiter #(
    parameter int unsigned ADDR_BITS      = 16,
    parameter int unsigned DATA_BITS      = 24,
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic           clk,
    input  logic           rst,
    sram_arbiter_if.slave  bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]           state, state_nxt;
    logic                 prio_wr, prio_wr_nxt;   // 1: write wins a tie
    logic                 io_start_q, io_start_nxt;
    logic                 io_writemode_q, io_writemode_nxt;
    logic [ADDR_BITS-1:0] io_address_q, io_address_nxt;
    logic [DATA_BITS-1:0] io_w_data_q, io_w_data_nxt;
    logic [DATA_BITS-1:0] rd_data_q, rd_data_nxt;
    logic                 rd_valid_q, rd_valid_nxt;
    logic                 wr_done_q, wr_done_nxt;
    logic                 err_q, err_nxt;
    logic                 grant_wr_c;
    logic                 timeout_c;

`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_BITS-1:0] wait_cnt;

    // WAIT-cycle counter, cleared whenever the FSM is outside WAIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wait_cnt <= '0;
        else if (state != WAIT)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + CNT_BITS'(1);
    end

    assign timeout_c = (wait_cnt == CNT_BITS'(TIMEOUT_CYCLES - 1));
`else
    logic timeout_param_unused;

    assign timeout_c            = 1'b0;
    assign timeout_param_unused = ^32'(TIMEOUT_CYCLES);
`endif

    // Tie-break: write only when read is absent or write holds the priority
    assign grant_wr_c = bus.wr_req && (!bus.rd_req || prio_wr);

    // Next-state and next-output decode
    always_comb begin
        state_nxt        = state;
        prio_wr_nxt      = prio_wr;
        io_start_nxt     = 1'b0;
        io_writemode_nxt = io_writemode_q;
        io_address_nxt   = io_address_q;
        io_w_data_nxt    = io_w_data_q;
        rd_data_nxt      = rd_data_q;
        rd_valid_nxt     = 1'b0;
        wr_done_nxt      = 1'b0;
        err_nxt          = 1'b0;

        case (state)
            IDLE: begin
                if (bus.rd_req || bus.wr_req) begin
                    io_writemode_nxt = grant_wr_c;
                    io_address_nxt   = grant_wr_c ? bus.wr_addr : bus.rd_addr;
                    if (grant_wr_c)
                        io_w_data_nxt = bus.wr_data;
                    io_start_nxt = 1'b1;
                    state_nxt    = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.io_done) begin
                    if (!io_writemode_q)
                        rd_data_nxt = bus.io_r_data;
                    rd_valid_nxt = !io_writemode_q;
                    wr_done_nxt  = io_writemode_q;
                    prio_wr_nxt  = !io_writemode_q;
                    state_nxt    = DONE;
                end else if (timeout_c) begin
                    err_nxt     = 1'b1;
                    prio_wr_nxt = !io_writemode_q;
                    state_nxt   = IDLE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            prio_wr        <= 1'b0;
            io_start_q     <= 1'b0;
            io_writemode_q <= 1'b0;
            io_address_q   <= '0;
            io_w_data_q    <= '0;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            wr_done_q      <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state          <= state_nxt;
            prio_wr        <= prio_wr_nxt;
            io_start_q     <= io_start_nxt;
            io_writemode_q <= io_writemode_nxt;
            io_address_q   <= io_address_nxt;
            io_w_data_q    <= io_w_data_nxt;
            rd_data_q      <= rd_data_nxt;
            rd_valid_q     <= rd_valid_nxt;
            wr_done_q      <= wr_done_nxt;
            err_q          <= err_nxt;
        end
    end

    assign bus.io_start     = io_start_q;
    assign bus.io_writemode = io_writemode_q;
    assign bus.io_address   = io_address_q;
    assign bus.io_w_data    = io_w_data_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.wr_done      = wr_done_q;
    assign bus.err_timeout  = err_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural sram_iface model, negedge monitor and
// an expected-transaction queue filled as requests are raised.
module tb_sram_arbiter;

    localparam int unsigned ADDR_BITS      = 16;
    localparam int unsigned DATA_BITS      = 24;
    localparam int unsigned TIMEOUT_CYCLES = 32;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [23:0] wdata;
        logic [23:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errs   = 0;
    int   cyc      = 0;
    int   starts   = 0;
    int   pulses   = 0;
    int   err_cnt  = 0;
    int   start_cyc = 0;
    int   done_cyc  = 0;
    int   err_cyc   = 0;
    bit   in_txn   = 1'b0;
    bit   stable   = 1'b1;
    bit   model_en = 1'b1;
    int   model_lat = 2;
    logic        wm_cap;
    logic [15:0] addr_cap;
    logic [23:0] wd_cap;
    logic [23:0] mem [logic [15:0]];

    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) bus ();

    sram_arbiter #(
        .ADDR_BITS      (ADDR_BITS),
        .DATA_BITS      (DATA_BITS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] mem_rd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : {8'h5A, a};
    endfunction

    task automatic push_exp(input logic wr, input logic [15:0] a, input logic [23:0] wd,
                            input logic [23:0] rd);
        exp_t e;
        e.wr = wr; e.addr = a; e.wdata = wd; e.rdata = rd;
        exp_q.push_back(e);
    endtask

    task automatic check_zero(input string pfx);
        check_eq({pfx, "_io_start"},     32'(bus.io_start), 32'd0);
        check_eq({pfx, "_io_writemode"}, 32'(bus.io_writemode), 32'd0);
        check_eq({pfx, "_io_address"},   32'(bus.io_address), 32'd0);
        check_eq({pfx, "_io_w_data"},    32'(bus.io_w_data), 32'd0);
        check_eq({pfx, "_rd_data"},      32'(bus.rd_data), 32'd0);
        check_eq({pfx, "_rd_valid"},     32'(bus.rd_valid), 32'd0);
        check_eq({pfx, "_wr_done"},      32'(bus.wr_done), 32'd0);
        check_eq({pfx, "_err_timeout"},  32'(bus.err_timeout), 32'd0);
    endtask

    task automatic wait_pulses(input int n, input string tag);
        int target;
        target = pulses + n;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); #1;
            if (pulses >= target) break;
        end
        if (pulses < target)
            check_eq({tag, "_pulse_timeout"}, 32'(pulses), 32'(target));
    endtask

    task automatic wait_start(input int s0, input string tag);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk); #1;
            if (starts > s0) break;
        end
        if (starts <= s0)
            check_eq({tag, "_start_timeout"}, 32'(starts), 32'(s0 + 1));
    endtask

    // cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // sram_iface model: io_done model_lat+1 cycles after the start strobe
    initial begin
        bit          busy;
        int          cnt;
        logic        mwm;
        logic [15:0] ma;
        logic [23:0] md;
        busy = 1'b0; cnt = 0; mwm = 1'b0; ma = '0; md = '0;
        bus.io_done   = 1'b0;
        bus.io_r_data = '0;
        forever begin
            @(posedge clk); #1;
            bus.io_done = 1'b0;
            if (!rst || !model_en) begin
                busy = 1'b0;
            end else begin
                if (busy) begin
                    if (cnt == 0) begin
                        bus.io_done = 1'b1;
                        busy = 1'b0;
                        if (mwm) mem[ma] = md;
                        else     bus.io_r_data = mem_rd(ma);
                    end else begin
                        cnt--;
                    end
                end
                if (bus.io_start) begin
                    busy = 1'b1;
                    cnt  = model_lat;
                    mwm  = bus.io_writemode;
                    ma   = bus.io_address;
                    md   = bus.io_w_data;
                end
            end
        end
    end

    // monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_txn = 1'b0;
            end else begin
                if (bus.io_start) begin
                    starts++;
                    start_cyc = cyc;
                    check_eq("start_while_busy", 32'(in_txn), 32'd0);
                    in_txn   = 1'b1;
                    stable   = 1'b1;
                    wm_cap   = bus.io_writemode;
                    addr_cap = bus.io_address;
                    wd_cap   = bus.io_w_data;
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_start", 32'd1, 32'd0);
                    end else begin
                        check_eq("grant_mode", 32'(bus.io_writemode), 32'(exp_q[0].wr));
                        check_eq("grant_addr", 32'(bus.io_address), 32'(exp_q[0].addr));
                        if (exp_q[0].wr)
                            check_eq("grant_wdata", 32'(bus.io_w_data), 32'(exp_q[0].wdata));
                    end
                end else if (in_txn) begin
                    if (bus.io_writemode !== wm_cap || bus.io_address !== addr_cap ||
                        bus.io_w_data !== wd_cap)
                        stable = 1'b0;
                end
                if (in_txn && bus.io_done)
                    done_cyc = cyc;
                if (bus.rd_valid || bus.wr_done) begin
                    pulses++;
                    if (!in_txn || exp_q.size() == 0) begin
                        check_eq("unexpected_pulse", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("pulse_wr_done", 32'(bus.wr_done), 32'(e.wr));
                        check_eq("pulse_rd_valid", 32'(bus.rd_valid), 32'(!e.wr));
                        if (!e.wr)
                            check_eq("rd_data", 32'(bus.rd_data), 32'(e.rdata));
                        check_eq("io_stable", 32'(stable), 32'd1);
                        check_eq("pulse_latency", 32'(cyc - done_cyc), 32'd1);
                    end
                    in_txn = 1'b0;
                end
                if (bus.err_timeout) begin
                    err_cnt++;
                    err_cyc = cyc;
                    if (in_txn && exp_q.size() > 0)
                        void'(exp_q.pop_front());
                    in_txn = 1'b0;
                end
            end
        end
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    // stimulus
    initial begin
        int s0;
        int p0;
        int e0;
        bit err_seen;
        rst = 1'b0;
        bus.rd_req  = 1'b0;
        bus.rd_addr = '0;
        bus.wr_req  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        mem[16'h0040] = 24'hABCDEF;
        #1;
        check_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // single read
        @(negedge clk);
        push_exp(1'b0, 16'h0040, 24'h0, 24'hABCDEF);
        bus.rd_req  = 1'b1;
        bus.rd_addr = 16'h0040;
        @(negedge clk); #1;
        check_eq("rd_start_n1", 32'(bus.io_start), 32'd1);
        check_eq("rd_mode", 32'(bus.io_writemode), 32'd0);
        @(negedge clk); #1;
        check_eq("start_one_cycle", 32'(bus.io_start), 32'd0);
        wait_pulses(1, "rd_single");
        bus.rd_req = 1'b0;

        // single write, longer sram latency
        repeat (2) @(negedge clk);
        model_lat = 4;
        push_exp(1'b1, 16'h1234, 24'h00FF00, 24'h0);
        bus.wr_req  = 1'b1;
        bus.wr_addr = 16'h1234;
        bus.wr_data = 24'h00FF00;
        wait_pulses(1, "wr_single");
        bus.wr_req = 1'b0;
        check_eq("wr_mem", 32'(mem_rd(16'h1234)), 32'h00FF00);
        check_eq("rd_data_hold", 32'(bus.rd_data), 32'hABCDEF);

        // contention: both held for four transactions, expect R W R W
        repeat (2) @(negedge clk);
        model_lat = 1;
        s0 = starts;
        push_exp(1'b0, 16'h0100, 24'h0, 24'h5A0100);
        push_exp(1'b1, 16'h0200, 24'h222222, 24'h0);
        push_exp(1'b0, 16'h0100, 24'h0, 24'h5A0100);
        push_exp(1'b1, 16'h0200, 24'h222222, 24'h0);
        bus.rd_addr = 16'h0100;
        bus.wr_addr = 16'h0200;
        bus.wr_data = 24'h222222;
        bus.rd_req  = 1'b1;
        bus.wr_req  = 1'b1;
        wait_pulses(4, "contention");
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("contention_starts", 32'(starts - s0), 32'd4);
        check_eq("contention_drained", 32'(exp_q.size()), 32'd0);

        // write request dropped during WAIT
        model_lat = 3;
        s0 = starts;
        push_exp(1'b1, 16'h2000, 24'h123456, 24'h0);
        bus.wr_addr = 16'h2000;
        bus.wr_data = 24'h123456;
        bus.wr_req  = 1'b1;
        wait_start(s0, "drop");
        @(negedge clk);
        bus.wr_req = 1'b0;
        wait_pulses(1, "drop");
        repeat (8) @(negedge clk);
        check_eq("drop_no_regrant", 32'(starts - s0), 32'd1);

        // read back the earlier write
        push_exp(1'b0, 16'h1234, 24'h0, 24'h00FF00);
        bus.rd_addr = 16'h1234;
        bus.rd_req  = 1'b1;
        wait_pulses(1, "readback");
        bus.rd_req = 1'b0;
        repeat (2) @(negedge clk);

        // reset while stuck in WAIT; afterwards read must win a tie
        model_en = 1'b0;
        s0 = starts;
        push_exp(1'b1, 16'h0300, 24'h333333, 24'h0);
        bus.wr_addr = 16'h0300;
        bus.wr_data = 24'h333333;
        bus.wr_req  = 1'b1;
        wait_start(s0, "rst_wait");
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_zero("rst_async");
        exp_q.delete();
        @(negedge clk); #1;
        check_zero("rst_held");
        model_en  = 1'b1;
        model_lat = 2;
        push_exp(1'b0, 16'h0300, 24'h0, 24'h5A0300);
        push_exp(1'b1, 16'h0300, 24'h333333, 24'h0);
        bus.rd_addr = 16'h0300;
        bus.rd_req  = 1'b1;
        rst = 1'b1;
        wait_pulses(2, "post_rst");
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("post_rst_drained", 32'(exp_q.size()), 32'd0);

        // sram never answers
        model_en = 1'b0;
        s0 = starts;
        p0 = pulses;
        e0 = err_cnt;
        err_seen = 1'b0;
        push_exp(1'b0, 16'h0500, 24'h0, 24'h0);
        bus.rd_addr = 16'h0500;
        bus.rd_req  = 1'b1;
        wait_start(s0, "timeout");
`ifdef SRAM_ARB_TIMEOUT_EN
        for (int k = 0; k < 60; k++) begin
            @(negedge clk); #1;
            if (err_cnt > e0) break;
        end
        bus.rd_req = 1'b0;
        check_eq("timeout_pulse_count", 32'(err_cnt - e0), 32'd1);
        check_eq("timeout_cycle", 32'(err_cyc - start_cyc), 32'(TIMEOUT_CYCLES + 1));
        @(negedge clk); #1;
        check_eq("timeout_one_cycle", 32'(bus.err_timeout), 32'd0);
        repeat (5) @(negedge clk);
        check_eq("timeout_no_rd_valid", 32'(pulses - p0), 32'd0);
        check_eq("timeout_rd_data_kept", 32'(bus.rd_data), 32'h5A0300);
        check_eq("timeout_no_regrant", 32'(starts - s0), 32'd1);
`else
        for (int k = 0; k < 60; k++) begin
            @(negedge clk); #1;
            if (bus.err_timeout) err_seen = 1'b1;
        end
        check_eq("no_timeout_err", 32'(err_seen), 32'd0);
        check_eq("no_timeout_no_rd_valid", 32'(pulses - p0), 32'd0);
        check_eq("no_timeout_rd_data_kept", 32'(bus.rd_data), 32'h5A0300);
        check_eq("no_timeout_single_start", 32'(starts - s0), 32'd1);
        bus.rd_req = 1'b0;
        #2;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
`endif
        model_en = 1'b1;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and sequencer in front of `sram_iface` in the edge-detector datapath. It lets the pixel-fetch path (read port) and the result-writeback path (write port) share the single SRAM interface. Each request is latched, presented as one `sram_iface` transaction (start strobe, mode, address, data held stable), and completed with a one-cycle response pulse. When both ports request at once, the arbiter alternates between them round-robin.

## Interface
- `ADDR_BITS`, 16, SRAM address width
- `DATA_BITS`, 24, SRAM data width (3 bytes, one RGB pixel)
- `TIMEOUT_CYCLES`, 32, watchdog limit in WAIT; used only with `SRAM_ARB_TIMEOUT_EN`

Ports:
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-low
- `rd_req` in 1: read request, level, held until `rd_valid`
- `rd_addr` in `ADDR_BITS`: read address
- `rd_data` out `DATA_BITS`: read data, registered, valid while `rd_valid`=1
- `rd_valid` out 1: one-cycle read completion pulse
- `wr_req` in 1: write request, level, held until `wr_done`
- `wr_addr` in `ADDR_BITS`: write address
- `wr_data` in `DATA_BITS`: write data
- `wr_done` out 1: one-cycle write completion pulse
- `io_start` out 1: start strobe to `sram_iface`
- `io_writemode` out 1: 0 = read, 1 = write
- `io_address` out `ADDR_BITS`: latched address
- `io_w_data` out `DATA_BITS`: latched write data
- `io_r_data` in `DATA_BITS`: read data from `sram_iface`
- `io_done` in 1: completion from `sram_iface`
- `err_timeout` out 1: one-cycle timeout pulse; constant 0 without the macro

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- **Reset:** state IDLE. All outputs 0. Priority pointer favours read.
- **IDLE:**
  - If either request is high, grant one and latch its address, mode and (for writes) data into the `io_*` registers, then go to ISSUE.
  - If both are high, grant the port not served last; immediately after reset, read wins.
  - Otherwise stay in IDLE.
- **ISSUE:** `io_start`=1 for exactly this cycle, then go to WAIT.
- **WAIT:** hold `io_*` stable. On `io_done`=1, capture `io_r_data` into `rd_data` (read only), flip the priority pointer, go to DONE.
- **DONE:** `rd_valid` or `wr_done`=1 for this cycle only, then go to IDLE.
- `io_writemode`, `io_address` and `io_w_data` stay constant from ISSUE through DONE. They change only on a new grant.
- `io_done` is ignored outside WAIT.
- If a request drops mid-transaction, the transaction still completes and its pulse is still produced.
- `rd_data` holds its last value until the next read completes.
- Asynchronous reset in any state returns to IDLE with outputs cleared. The partial SRAM transaction is abandoned; `sram_iface` shares the same reset.

## Timing
- A request sampled in IDLE at cycle N gives `io_start` at N+1 and WAIT from N+2.
- `io_done` sampled at cycle M gives the response pulse at M+1 and IDLE at M+2.
- A requester drops `req` on the clock edge after it sees the pulse. The arbiter re-samples requests no earlier than M+2.
- Minimum gap between back-to-back transactions is one IDLE cycle.
- End-to-end latency is 4 cycles plus the `sram_iface` transaction length.

## Configuration
- Macro `SRAM_ARB_TIMEOUT_EN`.
- **Defined:** a counter runs in WAIT and clears on entry. If it reaches `TIMEOUT_CYCLES` with no `io_done`:
  - pulse `err_timeout` for one cycle and return to IDLE;
  - produce no `rd_valid` or `wr_done`; leave `rd_data` unchanged;
  - flip the priority pointer.
- **Undefined:** no counter; WAIT waits indefinitely; `err_timeout` is tied to 0.

## Test plan
- **Reset:** assert `rst`=0 mid-WAIT → next cycle all outputs 0, state IDLE; with both requests then high, read is granted first.
- **Single read:** `rd_req`, `rd_addr`=16'h0040, model returns 24'hABCDEF → `io_start` pulse with `io_writemode`=0; `rd_valid` 1 cycle after `io_done`; `rd_data`=24'hABCDEF.
- **Single write:** `wr_addr`=16'h1234, `wr_data`=24'h00FF00 → `io_writemode`=1; address and data stable through WAIT; `wr_done` pulse; no `rd_valid`.
- **Contention:** both requests held high for 4 transactions → grant order R, W, R, W; exactly one `io_start` per transaction.
- **Request drop:** `wr_req` deasserted during WAIT → `wr_done` still pulses; no second grant.
- **Timeout (macro defined, `TIMEOUT_CYCLES`=32):** `io_done` never asserted → `err_timeout` pulse in the cycle after the 32nd WAIT cycle, then IDLE; no `rd_valid`. Macro undefined: the arbiter stays in WAIT and `err_timeout`=0.
